// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: constants and types shared between decode and execute.
// Holds the bus widths, the decode-to-execute bus field layout and the
// one-hot ALU op bit indices.
package ex_stage_pkg;

    localparam int unsigned DS2ES_W     = 116;
    localparam int unsigned ES2MS_W     = 71;
    localparam int unsigned ES_RF_ZIP_W = 39;
    localparam int unsigned ALU_OP_W    = 12;

    // ds2es_bus field positions (MSB / LSB)
    localparam int unsigned DS2ES_ALU_OP_MSB   = 115;
    localparam int unsigned DS2ES_ALU_OP_LSB   = 104;
    localparam int unsigned DS2ES_RES_MEM_BIT  = 103;
    localparam int unsigned DS2ES_SRC1_MSB     = 102;
    localparam int unsigned DS2ES_SRC1_LSB     = 71;
    localparam int unsigned DS2ES_SRC2_MSB     = 70;
    localparam int unsigned DS2ES_SRC2_LSB     = 39;
    localparam int unsigned DS2ES_MEM_WE_BIT   = 38;
    localparam int unsigned DS2ES_RF_WE_BIT    = 37;
    localparam int unsigned DS2ES_RF_WADDR_MSB = 36;
    localparam int unsigned DS2ES_RF_WADDR_LSB = 32;
    localparam int unsigned DS2ES_RKD_MSB      = 31;
    localparam int unsigned DS2ES_RKD_LSB      = 0;

    // ALU op one-hot bit indices
    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLT  = 2;
    localparam int unsigned ALU_SLTU = 3;
    localparam int unsigned ALU_AND  = 4;
    localparam int unsigned ALU_NOR  = 5;
    localparam int unsigned ALU_OR   = 6;
    localparam int unsigned ALU_XOR  = 7;
    localparam int unsigned ALU_SLL  = 8;
    localparam int unsigned ALU_SRL  = 9;
    localparam int unsigned ALU_SRA  = 10;
    localparam int unsigned ALU_LUI  = 11;

    // Packed view of ds2es_bus; field order matches the bit positions above.
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                res_from_mem;
        logic [31:0]         alu_src1;
        logic [31:0]         alu_src2;
        logic                mem_we;
        logic                rf_we;
        logic [4:0]          rf_waddr;
        logic [31:0]         rkd_value;
    } ds2es_t;

endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational 32-bit ALU with a one-hot op select.
// Ports:
//   alu_op  in  12  one-hot operation (see ex_stage_pkg ALU_* indices)
//   src1    in  32  first operand
//   src2    in  32  second operand; src2[4:0] is the shift amount
//   result  out 32  wrapped result; all-zero op yields 0
module ex_alu
    import ex_stage_pkg::*;
(
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [31:0]         src1,
    input  logic [31:0]         src2,
    output logic [31:0]         result
);

    logic        use_sub;
    logic [31:0] adder_b;
    logic [32:0] adder_sum;
    logic        slt_res;
    logic        sltu_res;
    logic [4:0]  shamt;

    // sub/slt/sltu share the adder as src1 + ~src2 + 1
    assign use_sub   = alu_op[ALU_SUB] | alu_op[ALU_SLT] | alu_op[ALU_SLTU];
    assign adder_b   = use_sub ? ~src2 : src2;
    assign adder_sum = {1'b0, src1} + {1'b0, adder_b} + {32'd0, use_sub};

    // Signed less-than: sign differs -> src1 negative; same sign -> difference negative
    assign slt_res  = (src1[31] & ~src2[31])
                    | (~(src1[31] ^ src2[31]) & adder_sum[31]);
    // Unsigned borrow: no carry out of the subtraction means src1 < src2
    assign sltu_res = ~adder_sum[32];
    assign shamt    = src2[4:0];

    always_comb begin
        result = 32'd0;
        if (alu_op[ALU_ADD] | alu_op[ALU_SUB]) result = result | adder_sum[31:0];
        if (alu_op[ALU_SLT])  result = result | {31'd0, slt_res};
        if (alu_op[ALU_SLTU]) result = result | {31'd0, sltu_res};
        if (alu_op[ALU_AND])  result = result | (src1 & src2);
        if (alu_op[ALU_NOR])  result = result | ~(src1 | src2);
        if (alu_op[ALU_OR])   result = result | (src1 | src2);
        if (alu_op[ALU_XOR])  result = result | (src1 ^ src2);
        if (alu_op[ALU_SLL])  result = result | (src1 << shamt);
        if (alu_op[ALU_SRL])  result = result | (src1 >> shamt);
        if (alu_op[ALU_SRA])  result = result | 32'($signed(src1) >>> shamt);
        if (alu_op[ALU_LUI])  result = result | src2;
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage LoongArch32 pipeline.
// Optional feature macro: ES_FLUSH_EN (adds the es_flush input).
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   ds2es_valid/bus   decode-to-execute handshake and 116-bit payload
//   ds_pc             PC of the instruction offered by decode
//   es_allowin        execute can accept this cycle
//   ms_allowin        memory stage can accept
//   es2ms_valid/bus   execute-to-memory handshake and 71-bit payload
//   es_rf_zip         valid-gated write-back info returned to decode
//   data_sram_*       data SRAM request (issued in the advance cycle only)
//   es_flush          kill the held instruction (ES_FLUSH_EN only)
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   ds2es_valid,
    output logic                   es_allowin,
    input  logic [DS2ES_W-1:0]     ds2es_bus,
    input  logic [31:0]            ds_pc,
    input  logic                   ms_allowin,
`ifdef ES_FLUSH_EN
    input  logic                   es_flush,
`endif
    output logic                   es2ms_valid,
    output logic [ES2MS_W-1:0]     es2ms_bus,
    output logic [ES_RF_ZIP_W-1:0] es_rf_zip,
    output logic                   data_sram_en,
    output logic [3:0]             data_sram_we,
    output logic [31:0]            data_sram_addr,
    output logic [31:0]            data_sram_wdata
);

    logic        es_valid;
    ds2es_t      es_payload;
    logic [31:0] es_pc;
    logic        es_ready_go;
    logic        es_kill;
    logic        es_go;
    logic [31:0] alu_result;

`ifdef ES_FLUSH_EN
    assign es_kill = es_flush;
`else
    assign es_kill = 1'b0;
`endif

    assign es_ready_go = 1'b1;
    assign es_allowin  = ~es_valid | (es_ready_go & ms_allowin);
    assign es2ms_valid = es_valid & es_ready_go & ~es_kill;
    // Instruction leaves for MEM this cycle; the SRAM request is tied to it
    assign es_go       = es_valid & ~es_kill & ms_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid <= 1'b0;
        end else if (es_kill) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= ds2es_valid;
        end
    end

    // Payload may load alongside a flush; es_valid=0 makes it inert.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_payload <= '0;
            es_pc      <= 32'd0;
        end else if (ds2es_valid && es_allowin) begin
            es_payload <= ds2es_t'(ds2es_bus);
            es_pc      <= ds_pc;
        end
    end

    ex_alu u_ex_alu (
        .alu_op (es_payload.alu_op),
        .src1   (es_payload.alu_src1),
        .src2   (es_payload.alu_src2),
        .result (alu_result)
    );

    assign data_sram_en    = es_go & (es_payload.res_from_mem | es_payload.mem_we);
    assign data_sram_we    = {4{es_go & es_payload.mem_we}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = es_payload.rkd_value;

    assign es2ms_bus = {es_payload.res_from_mem, es_payload.rf_we, es_payload.rf_waddr,
                        alu_result, es_pc};

    // Gated flags keep an empty stage from triggering bypass or load-use stalls
    assign es_rf_zip = {es_payload.res_from_mem & es_valid, es_payload.rf_we & es_valid,
                        es_payload.rf_waddr, alu_result};

endmodule
